sram_burst_io_ctrl: RTL and testbench
=====================================

// Module: sram_burst_io_ctrl
// PURPOSE
//  Serial-to-SRAM burst I/O controller. A serial header selects read or write, a start address and a burst length.
//  Writes: N data words are shifted in on SI, each written to SRAM at an auto-incrementing address.
//  Reads: N words are fetched from SRAM and shifted out on SO.
//  Sits between the chip-level serial test/load port and the instruction/data SRAM macro.
// PARAMETERS
//  MEMORY_DATA_WIDTH  8  SRAM word width (DW)
//  MEMORY_ADDR_WIDTH  9  SRAM address width (AW)
//  BURST_LEN_WIDTH    4  burst-length field width (LW); max burst 2^LW words
//  SRAM_RD_LAT        1  cycles from CEN low (read) to Q valid; range 1..3
// PORTS
//  CLK     in   1   clock; all logic on posedge
//  RST     in   1   synchronous reset, active-high
//  START   in   1   level input; the rising edge (registered 0->1) starts a transaction, honoured in IDLE only
//  SI      in   1   serial in, LSB first, sampled every posedge while shifting in
//  Q       in   DW  SRAM read data
//  RDY     out  1   1 in IDLE
//  DONE    out  1   one-cycle pulse when the last word completes
//  SO      out  1   serial out, LSB first
//  SO_VLD  out  1   1 while SO carries a valid read-data bit
//  CEN     out  1   SRAM chip enable, active-low
//  WEN     out  1   SRAM write enable, active-low
//  A       out  AW  SRAM address; 0 when CEN=1
//  D       out  DW  SRAM write data; 0 unless CEN=0 and WEN=0
// BEHAVIOUR
//  Reset values: RDY=1, DONE=0, SO=0, SO_VLD=0, CEN=1, WEN=1, A=0, D=0. All state, counters and shift registers clear.
//  Header (HW=1+AW+LW bits), shifted LSB first: bit0=CMD (1=write, 0=read), then ADDR[AW-1:0], then LEN[LW-1:0].
//  Words per burst = LEN+1; LEN=0 means one word.
//  States:
//    IDLE -> HDR on START edge.
//    HDR: HW cycles. Then -> WSHF if CMD=1, else -> RREQ.
//    WSHF: DW cycles shifting SI -> WWR.
//    WWR: 1 cycle; CEN=0, WEN=0, A=addr, D=word. -> WSHF if words remain, else -> FIN.
//    RREQ: 1 cycle; CEN=0, WEN=1, A=addr -> RWAIT.
//    RWAIT: SRAM_RD_LAT cycles; Q captured on the final RWAIT edge -> RSHF.
//    RSHF: DW cycles, SO_VLD=1, SO=word[i] for i=0..DW-1. -> RREQ if words remain, else -> FIN.
//    FIN: DONE=1 for 1 cycle -> IDLE.
//  CEN, WEN, SO and SO_VLD are decoded from the registered state, so they are glitch-free and change only at posedge.
//  The address increments after each WWR and each RREQ, mod 2^AW; 0x1FF+1 wraps to 0x000 with no error.
//  Latency: first SRAM write occurs HW+DW cycles after the START edge.
//  Read throughput: 1 word per (1+SRAM_RD_LAT+DW) cycles.
//  START is ignored outside IDLE. START held high does not retrigger; it must drop and rise again.
//  A START edge in the same cycle as DONE is ignored; the edge must occur while RDY=1.
//  RST mid-burst: next cycle returns to IDLE with CEN=1, WEN=1. No partial write is issued.
//  A word already written before RST stays in SRAM.
// CONFIGURATION
//  SRAM_IO_PARITY_EN defined:
//    Each serial write word is followed by 1 even-parity bit; WSHF lasts DW+1 cycles.
//    On mismatch, WWR is suppressed (CEN stays 1), the address still increments, and the sticky output PERR (1b) is set.
//    PERR clears on RST or on the next START edge.
//    Each read word is followed by its parity bit on SO; RSHF lasts DW+1 cycles with SO_VLD=1.
//  SRAM_IO_PARITY_EN undefined: no parity bits, no PERR port; timing exactly as above.
// STRUCTURE
//  Package sram_io_pkg: state encoding constants (IO_IDLE, IO_HDR, IO_WSHF, IO_WWR, IO_RREQ, IO_RWAIT, IO_RSHF, IO_FIN),
//    CMD_READ=0, CMD_WRITE=1, and the HW width function.
//  Sub-module sram_io_shifter: DW(+1)-bit bidirectional shift register with parallel load, serial in/out and a bit counter.
//    Used for the data path; the header uses its own HW-bit shift register in the top.
//  Top holds the FSM, word counter (LW+1 bits), address counter, START edge detect and RD_LAT counter.
// TESTING (DW=8, AW=9, LW=4, RD_LAT=1)
//  1. Write LEN=2, ADDR=0x010, data 0xA5, 0x3C, 0xFF -> 3 WWR cycles at A=0x010/0x011/0x012 with D=A5/3C/FF; DONE pulse; RDY=1.
//  2. Read LEN=2, ADDR=0x010 (SRAM model from test 1) -> SO streams A5, 3C, FF LSB first, 8 SO_VLD cycles each, 2-cycle gaps.
//  3. Write LEN=1, ADDR=0x1FF -> writes at 0x1FF then 0x000 (wrap).
//  4. START pulsed during HDR and during RSHF -> ignored; transaction completes unchanged. START held high after DONE -> no retrigger.
//  5. RST asserted on 3rd bit of the 2nd write word -> next cycle IDLE, CEN=1, WEN=1; only word 1 written.
//  6. With SRAM_IO_PARITY_EN: write 0x81 with parity 1 -> no write, PERR=1, A advances. Read 0x81 -> 9th SO bit=0.

Source files
------------

// File: rtl/sram_io_pkg.sv
// Shared definitions for the serial-to-SRAM burst I/O controller:
// FSM state encoding, command codes and the serial header width.
package sram_io_pkg;

  typedef enum logic [2:0] {
    IO_IDLE  = 3'd0,
    IO_HDR   = 3'd1,
    IO_WSHF  = 3'd2,
    IO_WWR   = 3'd3,
    IO_RREQ  = 3'd4,
    IO_RWAIT = 3'd5,
    IO_RSHF  = 3'd6,
    IO_FIN   = 3'd7
  } io_state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Header = CMD bit + start address + burst length field.
  function automatic int unsigned hdr_width(input int unsigned aw, input int unsigned lw);
    return 1 + aw + lw;
  endfunction

endpackage

// File: rtl/sram_io_shifter.sv
// Data-path shift register for the burst controller.
// Shifts right (LSB first) with serial input entering at the MSB, supports a
// parallel load, and counts shifts so the caller knows when a word is complete.
module sram_io_shifter #(
  parameter int unsigned SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          shift,
  input  logic [SW-1:0] load_data,
  input  logic          si,
  output logic [SW-1:0] data,
  output logic          last
);

  localparam int unsigned CW = $clog2(SW) + 1;

  logic [SW-1:0] sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign data = sh_q;
  assign last = (cnt_q == CW'(SW - 1));

  // Next shift-register value and bit count; counter wraps after the last bit.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (load) begin
      sh_d  = load_data;
      cnt_d = '0;
    end else if (shift) begin
      sh_d  = {si, sh_q[SW-1:1]};
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_burst_io_ctrl.sv
// Serial-to-SRAM burst I/O controller.
// A serial header (CMD, ADDR, LEN; LSB first) selects a burst of LEN+1 words
// that are either shifted in on SI and written to SRAM, or read from SRAM and
// shifted out on SO. Optional feature macro: SRAM_IO_PARITY_EN adds an even
// parity bit per serial word and the sticky PERR output.
module sram_burst_io_ctrl
  import sram_io_pkg::*;
#(
  parameter int unsigned MEMORY_DATA_WIDTH = 8,
  parameter int unsigned MEMORY_ADDR_WIDTH = 9,
  parameter int unsigned BURST_LEN_WIDTH   = 4,
  parameter int unsigned SRAM_RD_LAT       = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         START,
  input  logic                         SI,
  input  logic [MEMORY_DATA_WIDTH-1:0] Q,
  output logic                         RDY,
  output logic                         DONE,
  output logic                         SO,
  output logic                         SO_VLD,
  output logic                         CEN,
  output logic                         WEN,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] D
`ifdef SRAM_IO_PARITY_EN
  ,
  output logic                         PERR
`endif
);

  localparam int unsigned DW  = MEMORY_DATA_WIDTH;
  localparam int unsigned AW  = MEMORY_ADDR_WIDTH;
  localparam int unsigned LW  = BURST_LEN_WIDTH;
  localparam int unsigned HW  = hdr_width(AW, LW);
  localparam int unsigned HCW = $clog2(HW) + 1;
  localparam int unsigned WCW = LW + 1;
`ifdef SRAM_IO_PARITY_EN
  localparam int unsigned SW  = DW + 1;
`else
  localparam int unsigned SW  = DW;
`endif

  io_state_e       state_q, state_d;
  logic            start_q, start_d;
  logic [HW-1:0]   hdr_q, hdr_d;
  logic [HCW-1:0]  hcnt_q, hcnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [WCW-1:0]  words_q, words_d;
  logic [1:0]      lat_q, lat_d;
  logic            perr_q, perr_d;

  logic            start_edge;
  logic [HW-1:0]   hdr_full;
  logic            lat_last;
  logic            sh_load, sh_shift, sh_si, sh_last;
  logic [SW-1:0]   sh_load_data, sh_data;
  logic            wr_ok;
  logic            wr_go;

  assign start_edge = START & ~start_q;
  assign hdr_full   = {SI, hdr_q[HW-1:1]};
  assign lat_last   = (lat_q == 2'(SRAM_RD_LAT - 1));

  assign sh_shift   = (state_q == IO_WSHF) || (state_q == IO_RSHF);
  assign sh_si      = (state_q == IO_WSHF) ? SI : 1'b0;
  assign sh_load    = (state_q == IO_RWAIT) && lat_last;

`ifdef SRAM_IO_PARITY_EN
  assign sh_load_data = {^Q, Q};
  assign wr_ok        = ~(^sh_data);
  assign PERR         = perr_q;
`else
  assign sh_load_data = Q;
  assign wr_ok        = 1'b1;
`endif

  sram_io_shifter #(
    .SW (SW)
  ) u_shifter (
    .clk       (CLK),
    .rst       (RST),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_data (sh_load_data),
    .si        (sh_si),
    .data      (sh_data),
    .last      (sh_last)
  );

  // Outputs decoded from registered state only.
  assign wr_go  = (state_q == IO_WWR) && wr_ok;
  assign RDY    = (state_q == IO_IDLE);
  assign DONE   = (state_q == IO_FIN);
  assign SO_VLD = (state_q == IO_RSHF);
  assign SO     = (state_q == IO_RSHF) ? sh_data[0] : 1'b0;
  assign CEN    = ~(wr_go || (state_q == IO_RREQ));
  assign WEN    = ~wr_go;
  assign A      = CEN ? '0 : addr_q;
  assign D      = wr_go ? sh_data[DW-1:0] : '0;

  // Next-state logic: header capture, burst sequencing, address/word counters.
  always_comb begin
    state_d = state_q;
    start_d = START;
    hdr_d   = hdr_q;
    hcnt_d  = hcnt_q;
    addr_d  = addr_q;
    words_d = words_q;
    lat_d   = lat_q;
    perr_d  = perr_q;
    unique case (state_q)
      IO_IDLE: begin
        if (start_edge) begin
          state_d = IO_HDR;
          hcnt_d  = '0;
          perr_d  = 1'b0;
        end
      end
      IO_HDR: begin
        hdr_d = hdr_full;
        if (hcnt_q == HCW'(HW - 1)) begin
          hcnt_d  = '0;
          addr_d  = hdr_full[AW:1];
          words_d = {1'b0, hdr_full[HW-1:AW+1]} + WCW'(1);
          state_d = (hdr_full[0] == CMD_WRITE) ? IO_WSHF : IO_RREQ;
        end else begin
          hcnt_d = hcnt_q + HCW'(1);
        end
      end
      IO_WSHF: begin
        if (sh_last) state_d = IO_WWR;
      end
      IO_WWR: begin
        // A parity-rejected word still consumes its address slot.
        addr_d  = addr_q + AW'(1);
        words_d = words_q - WCW'(1);
        if (!wr_ok) perr_d = 1'b1;
        state_d = (words_q == WCW'(1)) ? IO_FIN : IO_WSHF;
      end
      IO_RREQ: begin
        addr_d  = addr_q + AW'(1);
        words_d = words_q - WCW'(1);
        lat_d   = '0;
        state_d = IO_RWAIT;
      end
      IO_RWAIT: begin
        if (lat_last) begin
          lat_d   = '0;
          state_d = IO_RSHF;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      IO_RSHF: begin
        if (sh_last) state_d = (words_q == '0) ? IO_FIN : IO_RREQ;
      end
      IO_FIN: begin
        state_d = IO_IDLE;
      end
      default: state_d = IO_IDLE;
    endcase
  end

  // Control registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IO_IDLE;
      start_q <= 1'b0;
      hdr_q   <= '0;
      hcnt_q  <= '0;
      addr_q  <= '0;
      words_q <= '0;
      lat_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      hdr_q   <= hdr_d;
      hcnt_q  <= hcnt_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      lat_q   <= lat_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: tb/tb_sram_burst_io_ctrl.sv
// Directed testbench for sram_burst_io_ctrl with a behavioural 1-cycle-latency
// SRAM model. Build with +define+SRAM_IO_PARITY_EN to cover the parity option.
module tb_sram_burst_io_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 9;
  localparam int unsigned LW = 4;
  localparam int unsigned HW = 1 + AW + LW;
`ifdef SRAM_IO_PARITY_EN
  localparam int unsigned SW = DW + 1;
`else
  localparam int unsigned SW = DW;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic          SI = 1'b0;
  logic [DW-1:0] Q;
  logic          RDY, DONE, SO, SO_VLD, CEN, WEN;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
`ifdef SRAM_IO_PARITY_EN
  logic          PERR;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] wdata [0:15];
  logic          wbad  [0:15];

  always #5 CLK = ~CLK;

  sram_burst_io_ctrl #(
    .MEMORY_DATA_WIDTH (DW),
    .MEMORY_ADDR_WIDTH (AW),
    .BURST_LEN_WIDTH   (LW),
    .SRAM_RD_LAT       (1)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .SI     (SI),
    .Q      (Q),
    .RDY    (RDY),
    .DONE   (DONE),
    .SO     (SO),
    .SO_VLD (SO_VLD),
    .CEN    (CEN),
    .WEN    (WEN),
    .A      (A),
    .D      (D)
`ifdef SRAM_IO_PARITY_EN
    ,
    .PERR   (PERR)
`endif
  );

  // SRAM model: synchronous write, read data valid one cycle after CEN low.
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) begin
      wdata[i] = '0;
      wbad[i]  = 1'b0;
    end
    Q = '0;
  end

  always @(posedge CLK) begin
    if (!CEN && !WEN) mem[A] <= D;
    if (!CEN && WEN)  Q <= mem[A];
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    tick;
    tick;
    checks++;
    if ({RDY, DONE, SO, SO_VLD, CEN, WEN, A, D} !== {6'b100011, 9'h000, 8'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", {RDY, DONE, SO, SO_VLD, CEN, WEN, A, D},
               {6'b100011, 9'h000, 8'h00});
    end
    RST = 1'b0;
    tick;
  endtask

  task automatic write_burst(input logic [AW-1:0] addr, input int unsigned nwords, input bit hold);
    logic [HW-1:0] hdr;
    logic          cen_ok;
    logic [AW-1:0] exp_a;
    hdr = {LW'(nwords - 1), addr, 1'b1};
    START = 1'b1;
    tick;
    START = 1'b0;
    for (int i = 0; i < int'(HW); i++) begin
      SI = hdr[i];
      tick;
    end
    for (int w = 0; w < int'(nwords); w++) begin
      cen_ok = 1'b1;
      for (int b = 0; b < int'(SW); b++) begin
        if (CEN !== 1'b1) cen_ok = 1'b0;
        SI = (b < int'(DW)) ? wdata[w][b] : ((^wdata[w]) ^ wbad[w]);
        tick;
      end
      checks++;
      if (cen_ok !== 1'b1) begin
        errors++;
        $display("FAIL wr_shift_idle word%0d: CEN went low while shifting", w);
      end
      exp_a = addr + AW'(w);
      checks++;
      if (wbad[w]) begin
        if ({CEN, WEN, A, D} !== {2'b11, 9'h000, 8'h00}) begin
          errors++;
          $display("FAIL wr_suppress word%0d: got CEN=%b WEN=%b A=%h D=%h want 1 1 000 00",
                   w, CEN, WEN, A, D);
        end
      end else if ({CEN, WEN, A, D} !== {2'b00, exp_a, wdata[w]}) begin
        errors++;
        $display("FAIL wr_cycle word%0d: got CEN=%b WEN=%b A=%h D=%h want 0 0 %h %h",
                 w, CEN, WEN, A, D, exp_a, wdata[w]);
      end
      SI = 1'b0;
      tick;
    end
    checks++;
    if ({DONE, RDY} !== 2'b10) begin
      errors++;
      $display("FAIL wr_done: got DONE=%b RDY=%b want 1 0", DONE, RDY);
    end
    if (hold) START = 1'b1;
    tick;
    checks++;
    if ({DONE, RDY} !== 2'b01) begin
      errors++;
      $display("FAIL wr_idle: got DONE=%b RDY=%b want 0 1", DONE, RDY);
    end
    if (hold) begin
      cen_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
        tick;
        if (RDY !== 1'b1 || CEN !== 1'b1) cen_ok = 1'b0;
      end
      checks++;
      if (cen_ok !== 1'b1) begin
        errors++;
        $display("FAIL start_hold: got retrigger (RDY=%b) want RDY held 1", RDY);
      end
      START = 1'b0;
      tick;
    end
  endtask

  task automatic read_burst(input logic [AW-1:0] addr, input int unsigned nwords, input bit poke);
    logic [HW-1:0] hdr;
    logic [SW-1:0] got, exp;
    logic          vld_ok;
    logic [AW-1:0] exp_a;
    hdr = {LW'(nwords - 1), addr, 1'b0};
    START = 1'b1;
    tick;
    START = 1'b0;
    for (int i = 0; i < int'(HW); i++) begin
      SI = hdr[i];
      START = (poke && i == 5);
      tick;
    end
    START = 1'b0;
    SI = 1'b0;
    for (int w = 0; w < int'(nwords); w++) begin
      exp_a = addr + AW'(w);
      checks++;
      if ({CEN, WEN, A, SO_VLD} !== {2'b01, exp_a, 1'b0}) begin
        errors++;
        $display("FAIL rd_req word%0d: got CEN=%b WEN=%b A=%h SO_VLD=%b want 0 1 %h 0",
                 w, CEN, WEN, A, SO_VLD, exp_a);
      end
      tick;
      checks++;
      if ({CEN, SO_VLD} !== 2'b10) begin
        errors++;
        $display("FAIL rd_wait word%0d: got CEN=%b SO_VLD=%b want 1 0", w, CEN, SO_VLD);
      end
      tick;
      vld_ok = 1'b1;
      got = '0;
      for (int b = 0; b < int'(SW); b++) begin
        if (SO_VLD !== 1'b1) vld_ok = 1'b0;
        got[b] = SO;
        START = (poke && w == 1 && b == 3);
        tick;
      end
      START = 1'b0;
`ifdef SRAM_IO_PARITY_EN
      exp = {^mem[exp_a], mem[exp_a]};
`else
      exp = mem[exp_a];
`endif
      checks++;
      if (got !== exp || vld_ok !== 1'b1) begin
        errors++;
        $display("FAIL rd_data word%0d: got %h vld=%b want %h vld=1", w, got, vld_ok, exp);
      end
    end
    checks++;
    if ({DONE, RDY, SO_VLD} !== 3'b100) begin
      errors++;
      $display("FAIL rd_done: got DONE=%b RDY=%b SO_VLD=%b want 1 0 0", DONE, RDY, SO_VLD);
    end
    tick;
    checks++;
    if ({DONE, RDY} !== 2'b01) begin
      errors++;
      $display("FAIL rd_idle: got DONE=%b RDY=%b want 0 1", DONE, RDY);
    end
  endtask

  task automatic test_write;
    wdata[0] = 8'hA5; wdata[1] = 8'h3C; wdata[2] = 8'hFF;
    write_burst(9'h010, 3, 1'b0);
    checks++;
    if ({mem[9'h010], mem[9'h011], mem[9'h012]} !== 24'hA53CFF) begin
      errors++;
      $display("FAIL wr_mem: got %h %h %h want a5 3c ff", mem[9'h010], mem[9'h011], mem[9'h012]);
    end
  endtask

  task automatic test_read;
    read_burst(9'h010, 3, 1'b0);
  endtask

  task automatic test_wrap;
    wdata[0] = 8'h11; wdata[1] = 8'h22;
    write_burst(9'h1FF, 2, 1'b0);
    checks++;
    if ({mem[9'h1FF], mem[9'h000]} !== 16'h1122) begin
      errors++;
      $display("FAIL wrap_mem: got %h %h want 11 22", mem[9'h1FF], mem[9'h000]);
    end
  endtask

  task automatic test_start_ignore;
    read_burst(9'h010, 3, 1'b1);
    wdata[0] = 8'h77;
    write_burst(9'h020, 1, 1'b1);
    checks++;
    if (mem[9'h020] !== 8'h77) begin
      errors++;
      $display("FAIL hold_mem: got %h want 77", mem[9'h020]);
    end
  endtask

  task automatic test_reset_mid;
    logic [HW-1:0] hdr;
    logic [DW-1:0] w1, w2;
    w1 = 8'h5A;
    w2 = 8'hC3;
    hdr = {4'd1, 9'h040, 1'b1};
    START = 1'b1;
    tick;
    START = 1'b0;
    for (int i = 0; i < int'(HW); i++) begin
      SI = hdr[i];
      tick;
    end
    for (int b = 0; b < int'(SW); b++) begin
      SI = (b < int'(DW)) ? w1[b] : ^w1;
      tick;
    end
    checks++;
    if ({CEN, WEN, A, D} !== {2'b00, 9'h040, w1}) begin
      errors++;
      $display("FAIL rst_word1: got CEN=%b WEN=%b A=%h D=%h want 0 0 040 5a", CEN, WEN, A, D);
    end
    tick;
    SI = w2[0];
    tick;
    SI = w2[1];
    tick;
    SI = w2[2];
    RST = 1'b1;
    tick;
    RST = 1'b0;
    checks++;
    if ({RDY, CEN, WEN, DONE} !== 4'b1110) begin
      errors++;
      $display("FAIL rst_mid: got RDY=%b CEN=%b WEN=%b DONE=%b want 1 1 1 0", RDY, CEN, WEN, DONE);
    end
    for (int i = 0; i < 10; i++) begin
      SI = 1'b1;
      tick;
    end
    SI = 1'b0;
    checks++;
    if ({mem[9'h040], mem[9'h041], RDY} !== {8'h5A, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL rst_mem: got %h %h RDY=%b want 5a 00 1", mem[9'h040], mem[9'h041], RDY);
    end
  endtask

`ifdef SRAM_IO_PARITY_EN
  task automatic test_parity;
    wdata[0] = 8'h81; wbad[0] = 1'b1;
    wdata[1] = 8'h42; wbad[1] = 1'b0;
    write_burst(9'h080, 2, 1'b0);
    wbad[0] = 1'b0;
    checks++;
    if ({PERR, mem[9'h080], mem[9'h081]} !== {1'b1, 8'h00, 8'h42}) begin
      errors++;
      $display("FAIL par_err: got PERR=%b %h %h want 1 00 42", PERR, mem[9'h080], mem[9'h081]);
    end
    wdata[0] = 8'h81;
    write_burst(9'h0A0, 1, 1'b0);
    checks++;
    if ({PERR, mem[9'h0A0]} !== {1'b0, 8'h81}) begin
      errors++;
      $display("FAIL par_clear: got PERR=%b %h want 0 81", PERR, mem[9'h0A0]);
    end
    read_burst(9'h0A0, 1, 1'b0);
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_write;
    test_read;
    test_wrap;
    test_start_ignore;
    test_reset_mid;
`ifdef SRAM_IO_PARITY_EN
    test_parity;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
